dma_write_arbiter: RTL and testbench
====================================

# dma_write_arbiter

Round-robin arbiter that shares one DMA write command channel and one DMA write data stream among N_REQ independent producers. Examples are the page-data writer and the control-record writer, or several GPU-bound streams. It sits between the producers and the DMA engine's axis_dma_write_cmd / axis_dma_write_data ports. It grants one producer per command, forwards that command, then forwards exactly that command's data burst before re-arbitrating.

## Interface
Parameters:
- N_REQ, 2, number of producers (2..8)
- DATA_W, 512, data beat width in bits; beat = 64 bytes
- LEN_W, 32, command length width in bytes

Ports:
- clk  in  1  user clock
- rst  in  1  asynchronous, active-high reset
- s_cmd_valid / s_cmd_ready  in / out  N_REQ  per-producer command handshake
- s_cmd_address  in  N_REQ*64  per-producer address, producer i at [64*i +: 64]
- s_cmd_length  in  N_REQ*LEN_W  per-producer byte length
- s_data_valid / s_data_ready / s_data_last  in / out / in  N_REQ  per-producer data handshake
- s_data_data  in  N_REQ*DATA_W  per-producer data
- s_data_keep  in  N_REQ*DATA_W/8  per-producer keep
- m_cmd  axis_mem_cmd.master  —  to DMA write command
- m_data  axi_stream.master  —  to DMA write data
- grant_id  out  3  index of current/last granted producer
- busy  out  1  high outside IDLE
- xfer_count  out  32  completed commands, wraps at 2^32

## Operation
- State machine: IDLE, CMD, DATA.
- IDLE:
  - If any s_cmd_valid, the round-robin arbiter picks the first requester strictly after the last grant, wrapping around.
  - Registers grant_id and the command's beat count = (length+63)>>6, using a LEN_W-bit add with carry kept.
  - Moves to CMD.
  - With no request, stays in IDLE.
- CMD:
  - m_cmd.valid = s_cmd_valid[grant]; m_cmd.address/length are muxed from the grant.
  - s_cmd_ready[grant] = m_cmd.ready; all other s_cmd_ready are 0.
  - On handshake, go to DATA, or to IDLE if beat count is 0 (xfer_count increments).
- DATA:
  - m_data.valid/data/keep/last are combinationally muxed from the grant.
  - s_data_ready[grant] = m_data.ready; all others are 0.
  - A beat counter increments on each valid&ready.
  - When the beat with last (or the final counted beat, see Configuration) is accepted, go to IDLE and increment xfer_count.
- The grant is held through CMD and DATA regardless of other requests, so there is no preemption.
- A producer is never granted data without a prior accepted command.
- The round-robin pointer updates only at the CMD handshake.

## Timing
- Reset values: busy 0, grant_id N_REQ-1 (so producer 0 wins first), xfer_count 0, m_cmd.valid 0, m_data.valid 0, m_data.last 0, all s_*_ready 0.
- Arbitration latency: 1 cycle from s_cmd_valid (in IDLE) to m_cmd.valid.
- The command and data paths are zero-latency passthrough, with no buffering.
- Turnaround: 1 idle cycle between the last data beat and the next m_cmd.valid.
- Requests arriving simultaneously resolve by round-robin order; a lone requester may be granted back-to-back.
- A beat with valid=1 and ready=0 is neither counted nor completes.
- Reset asserted mid-burst returns the block to IDLE immediately and drops all valids/readies; the partial burst is abandoned (the system resets the DMA engine too).

## Configuration
- DMA_WR_ARB_LEN_CHECK_EN defined:
  - DATA ends on the counted beat; m_data.last is forced high on that beat.
  - An s_data_last on an earlier beat is ignored, but err_count increments once per burst.
  - Adds output err_count (32 bits, reset 0).
- Not defined:
  - DATA ends only on s_data_last and m_data.last = s_data_last.
  - The beat counter and err_count are absent.

## Structure
- Package dma_arb_pkg holds:
  - the state enum (IDLE/CMD/DATA)
  - BEAT_BYTES = 64
  - a function that converts bytes to beats
- Sub-module rr_arbiter (N_REQ request vector, last-grant index in, grant one-hot/index out) is purely combinational and instantiated once.

## Test plan
- Single producer 0, length 0x80: m_cmd.valid one cycle after request; 2 beats forwarded; xfer_count=1; grant_id=0.
- Both producers request at once, each length 0x40, repeated 4 times: grants alternate 0,1,0,1…; no data interleaving within a burst.
- Length 0: command forwarded, no data beats, back to IDLE; xfer_count increments.
- m_data.ready toggled 1/0 randomly during a 0x200000 burst: exactly 32768 beats forwarded; last aligns with the final accepted beat.
- With DMA_WR_ARB_LEN_CHECK_EN, length 0x100 and producer asserting last on beat 2: m_data.last on beat 4; err_count=1.
- Assert rst during DATA beat 3: all valids/readies drop asynchronously; busy=0; the next request gets producer 0 first.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared definitions for dma_write_arbiter: FSM state type, beat size and
// the byte-length to 64-byte beat conversion.
package dma_arb_pkg;

    localparam int unsigned BEAT_BYTES = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Carry is kept so lengths near the top of the range still round up.
    function automatic logic [58:0] bytes_to_beats(input logic [63:0] len_bytes);
        logic [64:0] w_sum;
        w_sum = {1'b0, len_bytes} + 65'(BEAT_BYTES - 1);
        return w_sum[64:6];
    endfunction

endpackage

// File: rtl/dma_write_arbiter_if.sv
// Master-side DMA write command and AXI-stream data interfaces used by
// dma_write_arbiter.
interface axis_mem_cmd #(
    parameter int unsigned LEN_W = 32
);
    logic             valid;
    logic             ready;
    logic [63:0]      address;
    logic [LEN_W-1:0] length;

    modport master (output valid, output address, output length, input ready);
    modport slave  (input valid, input address, input length, output ready);
endinterface

interface axi_stream #(
    parameter int unsigned DATA_W = 512
);
    logic                valid;
    logic                ready;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] keep;
    logic                last;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester strictly
// after i_last, wrapping around.
module rr_arbiter
    import dma_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [2:0]       i_last,
    output logic [N_REQ-1:0] o_grant_oh,
    output logic [2:0]       o_grant_idx,
    output logic             o_any
);

    logic w_found;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = i_last;
        w_found     = 1'b0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!w_found && i_req[i] && (i == (32'(i_last) + off) % N_REQ)) begin
                    w_found       = 1'b1;
                    o_grant_oh[i] = 1'b1;
                    o_grant_idx   = 3'(i);
                end
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/dma_write_arbiter.sv
// Round-robin arbiter sharing one DMA write command/data channel among N_REQ
// producers. Optional DMA_WR_ARB_LEN_CHECK_EN ends bursts on the counted beat.
module dma_write_arbiter
    import dma_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned LEN_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          s_cmd_valid,
    output logic [N_REQ-1:0]          s_cmd_ready,
    input  logic [N_REQ*64-1:0]       s_cmd_address,
    input  logic [N_REQ*LEN_W-1:0]    s_cmd_length,
    input  logic [N_REQ-1:0]          s_data_valid,
    output logic [N_REQ-1:0]          s_data_ready,
    input  logic [N_REQ-1:0]          s_data_last,
    input  logic [N_REQ*DATA_W-1:0]   s_data_data,
    input  logic [N_REQ*DATA_W/8-1:0] s_data_keep,
    axis_mem_cmd.master               m_cmd,
    axi_stream.master                 m_data,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic [31:0]               xfer_count
`ifdef DMA_WR_ARB_LEN_CHECK_EN
    ,
    output logic [31:0]               err_count
`endif
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned BEAT_W = LEN_W - 5;

    arb_state_t        r_state;
    logic [2:0]        r_grant;
    logic [2:0]        r_rr_ptr;
    logic [BEAT_W-1:0] r_beats;
    logic [31:0]       r_xfer;

    logic [N_REQ-1:0]  w_arb_oh_unused;
    logic [2:0]        w_arb_idx;
    logic              w_arb_any;
    logic [LEN_W-1:0]  w_arb_len;
    logic [58:0]       w_beats_calc;
    logic [BEAT_W-1:0] w_new_beats;
    logic [58-BEAT_W:0] w_beats_hi_unused;

    logic              w_sel_cmd_valid;
    logic [63:0]       w_sel_addr;
    logic [LEN_W-1:0]  w_sel_len;
    logic              w_sel_dvalid;
    logic [DATA_W-1:0] w_sel_data;
    logic [KEEP_W-1:0] w_sel_keep;
    logic              w_sel_last;

    logic              w_cmd_hs;
    logic              w_data_hs;
    logic              w_data_end;
    logic              w_last_out;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr_arbiter (
        .i_req       (s_cmd_valid),
        .i_last      (r_rr_ptr),
        .o_grant_oh  (w_arb_oh_unused),
        .o_grant_idx (w_arb_idx),
        .o_any       (w_arb_any)
    );

    assign w_beats_calc      = bytes_to_beats(64'(w_arb_len));
    assign w_new_beats       = w_beats_calc[BEAT_W-1:0];
    assign w_beats_hi_unused = w_beats_calc[58:BEAT_W];

    // Length for the pending pick uses the arbiter index; everything else follows the held grant.
    always_comb begin
        w_arb_len       = '0;
        w_sel_cmd_valid = 1'b0;
        w_sel_addr      = '0;
        w_sel_len       = '0;
        w_sel_dvalid    = 1'b0;
        w_sel_data      = '0;
        w_sel_keep      = '0;
        w_sel_last      = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_arb_idx == 3'(i)) begin
                w_arb_len = s_cmd_length[i*LEN_W +: LEN_W];
            end
            if (r_grant == 3'(i)) begin
                w_sel_cmd_valid = s_cmd_valid[i];
                w_sel_addr      = s_cmd_address[i*64 +: 64];
                w_sel_len       = s_cmd_length[i*LEN_W +: LEN_W];
                w_sel_dvalid    = s_data_valid[i];
                w_sel_data      = s_data_data[i*DATA_W +: DATA_W];
                w_sel_keep      = s_data_keep[i*KEEP_W +: KEEP_W];
                w_sel_last      = s_data_last[i];
            end
        end
    end

    always_comb begin
        s_cmd_ready  = '0;
        s_data_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (r_grant == 3'(i)) begin
                s_cmd_ready[i]  = (r_state == CMD) && m_cmd.ready;
                s_data_ready[i] = (r_state == DATA) && m_data.ready;
            end
        end
    end

    assign w_cmd_hs  = (r_state == CMD) && w_sel_cmd_valid && m_cmd.ready;
    assign w_data_hs = (r_state == DATA) && w_sel_dvalid && m_data.ready;

`ifdef DMA_WR_ARB_LEN_CHECK_EN
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [31:0]       r_err;
    logic              r_err_seen;
    logic              w_final_beat;
    logic              w_early_last;

    assign w_final_beat = (r_beat_cnt == r_beats - BEAT_W'(1));
    assign w_data_end   = w_data_hs && w_final_beat;
    assign w_last_out   = w_final_beat;
    assign w_early_last = w_data_hs && w_sel_last && !w_final_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_err      <= '0;
            r_err_seen <= 1'b0;
        end else if (r_state == IDLE) begin
            r_beat_cnt <= '0;
            r_err_seen <= 1'b0;
        end else if (w_data_hs) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            // One error per burst no matter how many early lasts arrive.
            if (w_early_last && !r_err_seen) begin
                r_err      <= r_err + 32'd1;
                r_err_seen <= 1'b1;
            end
        end
    end

    assign err_count = r_err;
`else
    assign w_data_end = w_data_hs && w_sel_last;
    assign w_last_out = w_sel_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= 3'(N_REQ - 1);
            r_rr_ptr <= 3'(N_REQ - 1);
            r_beats  <= '0;
            r_xfer   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_grant <= w_arb_idx;
                        r_beats <= w_new_beats;
                        r_state <= CMD;
                    end
                end
                CMD: begin
                    if (w_cmd_hs) begin
                        r_rr_ptr <= r_grant;
                        if (r_beats == '0) begin
                            r_state <= IDLE;
                            r_xfer  <= r_xfer + 32'd1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_data_end) begin
                        r_state <= IDLE;
                        r_xfer  <= r_xfer + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_cmd.valid    = (r_state == CMD) && w_sel_cmd_valid;
    assign m_cmd.address  = w_sel_addr;
    assign m_cmd.length   = w_sel_len;

    assign m_data.valid   = (r_state == DATA) && w_sel_dvalid;
    assign m_data.data    = w_sel_data;
    assign m_data.keep    = w_sel_keep;
    assign m_data.last    = (r_state == DATA) && w_last_out;

    assign grant_id   = r_grant;
    assign busy       = (r_state != IDLE);
    assign xfer_count = r_xfer;

endmodule

// File: tb/tb_dma_write_arbiter.sv
// Directed self-checking bench for dma_write_arbiter (N_REQ=2).
module tb_dma_write_arbiter;

    localparam int unsigned N_REQ  = 2;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned LEN_W  = 32;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam logic [63:0] ADDR0  = 64'h0000_1000_0000_0000;
    localparam logic [63:0] ADDR1  = 64'hDEAD_0000_0000_1000;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_REQ-1:0]          s_cmd_valid;
    logic [N_REQ-1:0]          s_cmd_ready;
    logic [N_REQ*64-1:0]       s_cmd_address;
    logic [N_REQ*LEN_W-1:0]    s_cmd_length;
    logic [N_REQ-1:0]          s_data_valid;
    logic [N_REQ-1:0]          s_data_ready;
    logic [N_REQ-1:0]          s_data_last;
    logic [N_REQ*DATA_W-1:0]   s_data_data;
    logic [N_REQ*KEEP_W-1:0]   s_data_keep;
    logic [2:0]                grant_id;
    logic                      busy;
    logic [31:0]               xfer_count;
`ifdef DMA_WR_ARB_LEN_CHECK_EN
    logic [31:0]               err_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    axis_mem_cmd #(.LEN_W(LEN_W)) cmd_if ();
    axi_stream #(.DATA_W(DATA_W)) data_if ();

    dma_write_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_cmd_valid   (s_cmd_valid),
        .s_cmd_ready   (s_cmd_ready),
        .s_cmd_address (s_cmd_address),
        .s_cmd_length  (s_cmd_length),
        .s_data_valid  (s_data_valid),
        .s_data_ready  (s_data_ready),
        .s_data_last   (s_data_last),
        .s_data_data   (s_data_data),
        .s_data_keep   (s_data_keep),
        .m_cmd         (cmd_if),
        .m_data        (data_if),
        .grant_id      (grant_id),
        .busy          (busy),
        .xfer_count    (xfer_count)
`ifdef DMA_WR_ARB_LEN_CHECK_EN
        ,
        .err_count     (err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] beat_data(input int unsigned q, input int unsigned k);
        logic [31:0] w;
        w = {8'(q + 32'hA0), 24'(k)};
        return {16{w}};
    endfunction

    function automatic logic [KEEP_W-1:0] keep_of(input int unsigned q);
        return (q == 0) ? '1 : {32{2'b10}};
    endfunction

    task automatic set_data(input int unsigned q, input int unsigned k);
        s_data_data[DATA_W*q +: DATA_W] = beat_data(q, k);
        s_data_keep[KEEP_W*q +: KEEP_W] = keep_of(q);
    endtask

    // Waits for m_cmd.valid; returns after the accepting edge (ready held high).
    task automatic wait_grant(output int unsigned gid, output logic [63:0] addr,
                              output logic [LEN_W-1:0] len, output int unsigned cyc,
                              output bit ok);
        ok = 1'b0; gid = 7; addr = '0; len = '0; cyc = 0;
        for (int unsigned c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (cmd_if.valid === 1'b1) begin
                ok = 1'b1; gid = 32'(grant_id); addr = cmd_if.address;
                len = cmd_if.length; cyc = c;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Producer p streams beats; every producer holds data valid so leakage is visible.
    task automatic run_burst(input int unsigned p, input int unsigned last_idx, input bit rnd,
                             input int unsigned budget, output int unsigned beats,
                             output int unsigned errs, output int last_pos, output bit tmo);
        bit done;
        beats = 0; errs = 0; last_pos = -1; tmo = 1'b1; done = 1'b0;
        s_data_valid = '1;
        for (int unsigned q = 0; q < N_REQ; q++) set_data(q, 0);
        for (int unsigned c = 0; c < budget; c++) begin
            set_data(p, beats);
            s_data_last    = '0;
            s_data_last[p] = (beats == last_idx);
            data_if.ready  = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
            @(negedge clk);
            for (int unsigned q = 0; q < N_REQ; q++) begin
                if (q != p && s_data_ready[q] !== 1'b0) errs++;
            end
            if (s_data_ready[p] !== data_if.ready || data_if.valid !== 1'b1) errs++;
            if (data_if.valid && data_if.ready) begin
                if (data_if.data !== beat_data(p, beats) || data_if.keep !== keep_of(p)) errs++;
                if (data_if.last) begin
                    last_pos = int'(beats); done = 1'b1; tmo = 1'b0;
                end
                beats++;
            end
            @(posedge clk); #1;
            if (done) break;
        end
        s_data_valid = '0; s_data_last = '0; data_if.ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s_cmd_valid = '1; s_data_valid = '1; s_data_last = '1;
        cmd_if.ready = 1'b1; data_if.ready = 1'b1;
        s_cmd_address = {ADDR1, ADDR0}; s_cmd_length = '0;
        s_data_data = '0; s_data_keep = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0h want 0", busy); end
        n_vec++; if (grant_id !== 3'd1) begin n_err++; $display("FAIL rst_grant: got %0d want 1", grant_id); end
        n_vec++; if (xfer_count !== 32'd0) begin n_err++; $display("FAIL rst_xfer: got %0d want 0", xfer_count); end
        n_vec++; if (cmd_if.valid !== 1'b0) begin n_err++; $display("FAIL rst_cmd_valid: got %0h want 0", cmd_if.valid); end
        n_vec++; if (data_if.valid !== 1'b0 || data_if.last !== 1'b0) begin
            n_err++; $display("FAIL rst_data_vl: got %0h%0h want 00", data_if.valid, data_if.last); end
        n_vec++; if (s_cmd_ready !== 2'b00 || s_data_ready !== 2'b00) begin
            n_err++; $display("FAIL rst_readies: got %b/%b want 00/00", s_cmd_ready, s_data_ready); end
`ifdef DMA_WR_ARB_LEN_CHECK_EN
        n_vec++; if (err_count !== 32'd0) begin n_err++; $display("FAIL rst_err: got %0d want 0", err_count); end
`endif
        @(posedge clk); #1;
        s_cmd_valid = '0; s_data_valid = '0; s_data_last = '0; rst = 1'b0;
    endtask

    task automatic test_single;
        int unsigned beats, errs; int last_pos; bit tmo;
        s_cmd_length = {32'h1234, 32'h80};
        s_cmd_valid = 2'b01;
        @(negedge clk);
        n_vec++; if (cmd_if.valid !== 1'b0) begin n_err++; $display("FAIL single_lat0: got %0h want 0", cmd_if.valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (cmd_if.valid !== 1'b1 || grant_id !== 3'd0 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_cmd: got v%0h g%0d b%0h want v1 g0 b1", cmd_if.valid, grant_id, busy); end
        n_vec++; if (cmd_if.address !== ADDR0 || cmd_if.length !== 32'h80) begin
            n_err++; $display("FAIL single_cmd_fields: got %h/%h want %h/80", cmd_if.address, cmd_if.length, ADDR0); end
        n_vec++; if (s_cmd_ready !== 2'b01) begin n_err++; $display("FAIL single_cmd_ready: got %b want 01", s_cmd_ready); end
        @(posedge clk); #1;
        s_cmd_valid = '0;
        run_burst(0, 1, 1'b0, 20, beats, errs, last_pos, tmo);
        n_vec++; if (beats != 2 || last_pos != 1 || errs != 0 || tmo) begin
            n_err++; $display("FAIL single_burst: got beats %0d last %0d errs %0d tmo %0d want 2 1 0 0", beats, last_pos, errs, tmo); end
        n_vec++; if (xfer_count !== 32'd1 || grant_id !== 3'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_done: got x%0d g%0d b%0h want x1 g0 b0", xfer_count, grant_id, busy); end
    endtask

    task automatic test_zero_len;
        int unsigned gid, cyc; logic [63:0] addr; logic [LEN_W-1:0] len; bit ok;
        s_cmd_length = {32'h0, 32'h40};
        s_cmd_valid = 2'b10; s_data_valid = 2'b10;
        wait_grant(gid, addr, len, cyc, ok);
        s_cmd_valid = '0;
        n_vec++; if (!ok || gid != 1 || addr !== ADDR1 || len !== 32'h0) begin
            n_err++; $display("FAIL zero_cmd: got ok%0d g%0d a%h l%h want ok1 g1 a%h l0", ok, gid, addr, len, ADDR1); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || data_if.valid !== 1'b0 || s_data_ready !== 2'b00) begin
            n_err++; $display("FAIL zero_idle: got b%0h v%0h r%b want b0 v0 r00", busy, data_if.valid, s_data_ready); end
        n_vec++; if (xfer_count !== 32'd2) begin n_err++; $display("FAIL zero_xfer: got %0d want 2", xfer_count); end
        s_data_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        int unsigned gid, cyc, beats, errs; logic [63:0] addr; logic [LEN_W-1:0] len;
        int last_pos; bit ok, tmo;
        s_cmd_length = {32'h40, 32'h40};
        s_cmd_valid = 2'b11;
        for (int unsigned r = 0; r < 8; r++) begin
            wait_grant(gid, addr, len, cyc, ok);
            n_vec++; if (!ok || gid != r % 2 || cyc != 2) begin
                n_err++; $display("FAIL rr_grant%0d: got ok%0d g%0d cyc%0d want ok1 g%0d cyc2", r, ok, gid, cyc, r % 2); end
            n_vec++; if (addr !== ((r % 2 == 0) ? ADDR0 : ADDR1)) begin
                n_err++; $display("FAIL rr_addr%0d: got %h want %h", r, addr, (r % 2 == 0) ? ADDR0 : ADDR1); end
            run_burst(r % 2, 0, 1'b0, 10, beats, errs, last_pos, tmo);
            n_vec++; if (beats != 1 || last_pos != 0 || errs != 0 || tmo) begin
                n_err++; $display("FAIL rr_burst%0d: got beats %0d errs %0d tmo %0d want 1 0 0", r, beats, errs, tmo); end
        end
        s_cmd_valid = '0;
        n_vec++; if (xfer_count !== 32'd10) begin n_err++; $display("FAIL rr_xfer: got %0d want 10", xfer_count); end
    endtask

    task automatic test_long_burst;
        int unsigned gid, cyc, beats, errs; logic [63:0] addr; logic [LEN_W-1:0] len;
        int last_pos; bit ok, tmo;
        s_cmd_length = {32'h40, 32'h0020_0000};
        s_cmd_valid = 2'b01;
        wait_grant(gid, addr, len, cyc, ok);
        s_cmd_valid = '0;
        n_vec++; if (!ok || gid != 0 || len !== 32'h0020_0000) begin
            n_err++; $display("FAIL long_cmd: got ok%0d g%0d l%h want ok1 g0 l200000", ok, gid, len); end
        run_burst(0, 32767, 1'b1, 90000, beats, errs, last_pos, tmo);
        n_vec++; if (beats != 32768 || last_pos != 32767 || errs != 0 || tmo) begin
            n_err++; $display("FAIL long_burst: got beats %0d last %0d errs %0d tmo %0d want 32768 32767 0 0", beats, last_pos, errs, tmo); end
        n_vec++; if (xfer_count !== 32'd11 || busy !== 1'b0) begin
            n_err++; $display("FAIL long_done: got x%0d b%0h want x11 b0", xfer_count, busy); end
    endtask

`ifdef DMA_WR_ARB_LEN_CHECK_EN
    task automatic test_len_check;
        int unsigned gid, cyc, beats, errs; logic [63:0] addr; logic [LEN_W-1:0] len;
        int last_pos; bit ok, tmo;
        s_cmd_length = {32'h40, 32'h100};
        s_cmd_valid = 2'b01;
        wait_grant(gid, addr, len, cyc, ok);
        s_cmd_valid = '0;
        n_vec++; if (!ok || gid != 0) begin n_err++; $display("FAIL lenchk_cmd: got ok%0d g%0d want ok1 g0", ok, gid); end
        run_burst(0, 1, 1'b0, 20, beats, errs, last_pos, tmo);
        n_vec++; if (beats != 4 || last_pos != 3 || errs != 0 || tmo) begin
            n_err++; $display("FAIL lenchk_burst: got beats %0d last %0d errs %0d want 4 3 0", beats, last_pos, errs); end
        n_vec++; if (err_count !== 32'd1 || xfer_count !== 32'd12) begin
            n_err++; $display("FAIL lenchk_err: got e%0d x%0d want e1 x12", err_count, xfer_count); end
    endtask
`endif

    task automatic test_reset_mid;
        int unsigned gid, cyc, beats, errs; logic [63:0] addr; logic [LEN_W-1:0] len;
        int last_pos; bit ok, tmo;
        s_cmd_length = {32'h40, 32'h200};
        s_cmd_valid = 2'b01;
        wait_grant(gid, addr, len, cyc, ok);
        s_cmd_valid = '0;
        n_vec++; if (!ok || gid != 0) begin n_err++; $display("FAIL rmid_cmd: got ok%0d g%0d want ok1 g0", ok, gid); end
        s_data_valid = 2'b01; data_if.ready = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            set_data(0, k);
            @(posedge clk); #1;
        end
        set_data(0, 3);
        #2;
        n_vec++; if (data_if.valid !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL rmid_pre: got v%0h b%0h want v1 b1", data_if.valid, busy); end
        rst = 1'b1;
        #1;
        n_vec++; if (data_if.valid !== 1'b0 || cmd_if.valid !== 1'b0 || s_data_ready !== 2'b00 || s_cmd_ready !== 2'b00) begin
            n_err++; $display("FAIL rmid_drop: got dv%0h cv%0h dr%b cr%b want 0 0 00 00", data_if.valid, cmd_if.valid, s_data_ready, s_cmd_ready); end
        n_vec++; if (busy !== 1'b0 || xfer_count !== 32'd0 || grant_id !== 3'd1) begin
            n_err++; $display("FAIL rmid_state: got b%0h x%0d g%0d want b0 x0 g1", busy, xfer_count, grant_id); end
        @(posedge clk); #1;
        rst = 1'b0; s_data_valid = '0;
        s_cmd_length = {32'h40, 32'h40};
        s_cmd_valid = 2'b11;
        wait_grant(gid, addr, len, cyc, ok);
        s_cmd_valid = '0;
        n_vec++; if (!ok || gid != 0 || cyc != 2) begin
            n_err++; $display("FAIL rmid_regrant: got ok%0d g%0d cyc%0d want ok1 g0 cyc2", ok, gid, cyc); end
        run_burst(0, 0, 1'b0, 10, beats, errs, last_pos, tmo);
        n_vec++; if (beats != 1 || errs != 0 || tmo || xfer_count !== 32'd1) begin
            n_err++; $display("FAIL rmid_burst: got beats %0d errs %0d x%0d want 1 0 1", beats, errs, xfer_count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_zero_len;
        test_round_robin;
        test_long_burst;
`ifdef DMA_WR_ARB_LEN_CHECK_EN
        test_len_check;
`endif
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
